obstacle_scheduler: RTL and testbench
=====================================

// Module: obstacle_scheduler
// PURPOSE
//  Owns the obstacle lane of the runner game: allocates up to NUM_SLOTS obstacle slots, spawns
//  them at pseudo-random tick gaps, scrolls them left at a ramping speed and retires them
//  off-screen. Sits between the game FSM (start/halt) and the renderer/collision logic
//  (obs_valid/obs_x). All updates advance only on tick, the one-per-frame enable.
// PARAMETERS
//  NUM_SLOTS   4         obstacle slots; slot 0 has highest allocation priority
//  X_SPAWN     800       x loaded into a newly spawned slot (10-bit hCount space)
//  X_DESPAWN   150       slot retires when its x <= X_DESPAWN; must be >= V_MAX
//  MIN_GAP     30        minimum ticks between spawns
//  GAP_MASK    63        random extra gap = lfsr[15:0] & GAP_MASK
//  V_INIT      6         initial velocity, pixels per tick
//  V_MAX       15        velocity saturation value, < 32
//  RAMP_TICKS  600       ticks between velocity increments
//  LFSR_SEED   16'hACE1  LFSR reset value, nonzero
// PORTS
//  clk            in   1             system clock
//  rst            in   1             asynchronous reset, active-high
//  tick           in   1             frame enable, 1-clk pulse
//  start          in   1             clear lane and (re)start scrolling
//  halt           in   1             freeze lane (game over)
//  obs_valid      out  NUM_SLOTS     bit i = slot i occupied
//  obs_x          out  10*NUM_SLOTS  slot i x at [10*i+9:10*i]; 0 when slot invalid
//  velocity       out  5             current pixels per tick
//  spawn_pulse    out  1             1-clk pulse: a slot was allocated this tick
//  despawn_pulse  out  1             1-clk pulse: >=1 slot retired this tick (score event)
//  spawn_stall    out  1             level: gap expired but no free slot
//  sched_state    out  2             00 IDLE, 01 RUN, 10 FROZEN
// BEHAVIOUR
//  - Reset: state IDLE, obs_valid=0, obs_x=0, velocity=V_INIT, pulses/stall=0, gap_cnt=MIN_GAP,
//    ramp_cnt=0, lfsr=LFSR_SEED. All outputs registered; effects visible 1 clk after sampling edge.
//  - LFSR: 16-bit Galois, taps 16,14,13,11 (mask 16'hB400); shifts every clk in every state.
//  - IDLE: lane empty, velocity held. start -> RUN (clear performed). halt ignored.
//  - RUN, on tick, in this order from pre-tick values:
//    1) each valid slot: if x <= X_DESPAWN -> valid=0, x=0, despawn_pulse=1; else x -= velocity.
//    2) gap_cnt: if >0, decrement. If already 0: if a slot is free (pre-tick, excluding slots
//       freed in step 1), lowest free index gets valid=1, x=X_SPAWN, spawn_pulse=1,
//       gap_cnt=MIN_GAP+(lfsr&GAP_MASK), spawn_stall=0; else spawn_stall=1, gap_cnt stays 0.
//    3) ramp_cnt+1; when it reaches RAMP_TICKS: ramp_cnt=0, velocity=min(velocity+1,V_MAX).
//    Non-tick cycles: everything held, pulses 0.
//  - RUN: halt -> FROZEN, takes effect at that edge (a coincident tick is NOT applied).
//  - FROZEN: all slot state, velocity, counters held; outputs stay visible for rendering.
//    start -> RUN with clear.
//  - start (any state): obs_valid=0, obs_x=0, velocity=V_INIT, gap_cnt=MIN_GAP, ramp_cnt=0,
//    stall=0, state RUN. start has priority over halt and over a coincident tick.
//  - Widths: x 10-bit unsigned; no underflow since x > X_DESPAWN >= V_MAX at subtract.
//  - Reset mid-run: immediate return to reset values regardless of tick.
// TESTING
//  1 rst, start, 31 ticks -> first spawn_pulse on tick 31 (gap 30 ticks then allocate), slot0
//    x=800, obs_valid=4'b0001; next tick x=794.
//  2 Slot0 valid at x=152, vel 6 -> tick: x=146; next tick: valid=0, x=0, despawn_pulse=1 once.
//  3 Force gap expiry with 4 slots full -> spawn_stall=1, no spawn; next tick after a despawn
//    -> slot of lowest free index allocated, stall=0.
//  4 600 ticks in RUN -> velocity 7; 5400 ticks -> 15; further ramps keep 15.
//  5 halt and tick same clk -> FROZEN, x unchanged; 100 ticks -> no change; start -> all slots 0,
//    velocity=6, state RUN.
//  6 Assert rst mid-RUN between ticks -> all outputs reset values asynchronously, lfsr=16'hACE1.

Source files
------------

// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: owns the obstacle lane of the runner game.
// Slots spawn at X_SPAWN after a pseudo-random tick gap, scroll left by the
// current velocity on every tick, and retire once they reach X_DESPAWN.
// Velocity ramps by one every RAMP_TICKS ticks, saturating at V_MAX.
module obstacle_scheduler #(
    parameter int          NUM_SLOTS  = 4,
    parameter int          X_SPAWN    = 800,
    parameter int          X_DESPAWN  = 150,
    parameter int          MIN_GAP    = 30,
    parameter int          GAP_MASK   = 63,
    parameter int          V_INIT     = 6,
    parameter int          V_MAX      = 15,
    parameter int          RAMP_TICKS = 600,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic                    start,
    input  logic                    halt,
    output logic [NUM_SLOTS-1:0]    obs_valid,
    output logic [10*NUM_SLOTS-1:0] obs_x,
    output logic [4:0]              velocity,
    output logic                    spawn_pulse,
    output logic                    despawn_pulse,
    output logic                    spawn_stall,
    output logic [1:0]              sched_state
);

    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int GAP_W  = $clog2(MIN_GAP + GAP_MASK + 1);
    localparam int RAMP_W = $clog2(RAMP_TICKS + 1);

    localparam logic [9:0]        X_SPAWN_X   = 10'(X_SPAWN);
    localparam logic [9:0]        X_DESPAWN_X = 10'(X_DESPAWN);
    localparam logic [4:0]        V_INIT_V    = 5'(V_INIT);
    localparam logic [4:0]        V_MAX_V     = 5'(V_MAX);
    localparam logic [GAP_W-1:0]  MIN_GAP_G   = GAP_W'(MIN_GAP);
    localparam logic [15:0]       GAP_MASK_L  = 16'(GAP_MASK);
    localparam logic [RAMP_W-1:0] RAMP_LAST   = RAMP_W'(RAMP_TICKS - 1);
    localparam logic [15:0]       LFSR_TAPS   = 16'hB400;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RUN    = 2'b01,
        S_FROZEN = 2'b10
    } state_t;

    // Galois step, taps 16,14,13,11
    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ LFSR_TAPS) : (l >> 1);
    endfunction

    // Velocity increment saturating at V_MAX
    function automatic logic [4:0] vel_sat_inc(input logic [4:0] v);
        return (v >= V_MAX_V) ? V_MAX_V : v + 5'd1;
    endfunction

    state_t                      state_q, state_d;
    logic [NUM_SLOTS-1:0]        valid_q, valid_d;
    logic [NUM_SLOTS-1:0][9:0]   x_q, x_d;
    logic [4:0]                  vel_q, vel_d;
    logic [GAP_W-1:0]            gap_q, gap_d;
    logic [RAMP_W-1:0]           ramp_q, ramp_d;
    logic [15:0]                 lfsr_q, lfsr_d;
    logic                        spawn_q, spawn_d;
    logic                        despawn_q, despawn_d;
    logic                        stall_q, stall_d;
    logic                        found;
    logic [SLOT_W-1:0]           free_idx;

    // Next-state: start clears the lane, RUN advances one frame per tick,
    // halt freezes everything (including a coincident tick).
    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        x_d       = x_q;
        vel_d     = vel_q;
        gap_d     = gap_q;
        ramp_d    = ramp_q;
        stall_d   = stall_q;
        spawn_d   = 1'b0;
        despawn_d = 1'b0;
        lfsr_d    = lfsr_next(lfsr_q);
        found     = 1'b0;
        free_idx  = '0;

        // Lowest free slot, judged on pre-tick occupancy so a slot retiring
        // this tick cannot be reused until the next one.
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                found    = 1'b1;
                free_idx = SLOT_W'(i);
            end
        end

        if (start) begin
            state_d = S_RUN;
            valid_d = '0;
            x_d     = '0;
            vel_d   = V_INIT_V;
            gap_d   = MIN_GAP_G;
            ramp_d  = '0;
            stall_d = 1'b0;
        end else if (state_q == S_RUN) begin
            if (halt) begin
                state_d = S_FROZEN;
            end else if (tick) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (valid_q[i]) begin
                        if (x_q[i] <= X_DESPAWN_X) begin
                            valid_d[i] = 1'b0;
                            x_d[i]     = '0;
                            despawn_d  = 1'b1;
                        end else begin
                            x_d[i] = x_q[i] - {5'd0, vel_q};
                        end
                    end
                end

                if (gap_q != '0) begin
                    gap_d = gap_q - 1'b1;
                end else if (found) begin
                    valid_d[free_idx] = 1'b1;
                    x_d[free_idx]     = X_SPAWN_X;
                    spawn_d           = 1'b1;
                    gap_d             = MIN_GAP_G + GAP_W'(lfsr_q & GAP_MASK_L);
                    stall_d           = 1'b0;
                end else begin
                    stall_d = 1'b1;
                end

                if (ramp_q == RAMP_LAST) begin
                    ramp_d = '0;
                    vel_d  = vel_sat_inc(vel_q);
                end else begin
                    ramp_d = ramp_q + 1'b1;
                end
            end
        end
    end

    // State and output registers, asynchronously reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            valid_q   <= '0;
            x_q       <= '0;
            vel_q     <= V_INIT_V;
            gap_q     <= MIN_GAP_G;
            ramp_q    <= '0;
            lfsr_q    <= LFSR_SEED;
            spawn_q   <= 1'b0;
            despawn_q <= 1'b0;
            stall_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            x_q       <= x_d;
            vel_q     <= vel_d;
            gap_q     <= gap_d;
            ramp_q    <= ramp_d;
            lfsr_q    <= lfsr_d;
            spawn_q   <= spawn_d;
            despawn_q <= despawn_d;
            stall_q   <= stall_d;
        end
    end

    assign obs_valid     = valid_q;
    assign obs_x         = x_q;
    assign velocity      = vel_q;
    assign spawn_pulse   = spawn_q;
    assign despawn_pulse = despawn_q;
    assign spawn_stall   = stall_q;
    assign sched_state   = state_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Bench for obstacle_scheduler: two instances (default parameters and a
// short-gap variant that fills the lane) share stimulus; a behavioural model
// queues the expected outputs per cycle, plus targeted spot checks.
module tb_obstacle_scheduler;

    logic clk = 1'b0;
    logic rst, tick, start, halt;

    logic [3:0]  obs_valid_a, obs_valid_b;
    logic [39:0] obs_x_a, obs_x_b;
    logic [4:0]  velocity_a, velocity_b;
    logic        spawn_pulse_a, spawn_pulse_b;
    logic        despawn_pulse_a, despawn_pulse_b;
    logic        spawn_stall_a, spawn_stall_b;
    logic [1:0]  sched_state_a, sched_state_b;

    int n_pass   = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    obstacle_scheduler dut_a (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .halt(halt),
        .obs_valid(obs_valid_a), .obs_x(obs_x_a), .velocity(velocity_a),
        .spawn_pulse(spawn_pulse_a), .despawn_pulse(despawn_pulse_a),
        .spawn_stall(spawn_stall_a), .sched_state(sched_state_a)
    );

    obstacle_scheduler #(.MIN_GAP(2), .GAP_MASK(3)) dut_b (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .halt(halt),
        .obs_valid(obs_valid_b), .obs_x(obs_x_b), .velocity(velocity_b),
        .spawn_pulse(spawn_pulse_b), .despawn_pulse(despawn_pulse_b),
        .spawn_stall(spawn_stall_b), .sched_state(sched_state_b)
    );

    logic [63:0] obs_a, obs_b;
    assign obs_a = {10'd0, sched_state_a, spawn_stall_a, despawn_pulse_a, spawn_pulse_a,
                    velocity_a, obs_valid_a, obs_x_a};
    assign obs_b = {10'd0, sched_state_b, spawn_stall_b, despawn_pulse_b, spawn_pulse_b,
                    velocity_b, obs_valid_b, obs_x_b};

    typedef struct packed {
        logic [1:0]      st;
        logic            stall;
        logic            dp;
        logic            sp;
        logic [4:0]      vel;
        logic [3:0]      valid;
        logic [3:0][9:0] x;
        logic [6:0]      gap;
        logic [9:0]      ramp;
        logic [15:0]     lfsr;
    } mdl_t;

    mdl_t ma, mb;
    logic [63:0] exp_a_q[$];
    logic [63:0] exp_b_q[$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    function automatic mdl_t mdl_reset(input int mg);
        mdl_t m;
        m       = '0;
        m.vel   = 5'd6;
        m.gap   = 7'(mg);
        m.lfsr  = 16'hACE1;
        return m;
    endfunction

    function automatic logic [63:0] pack_exp(input mdl_t m);
        return {10'd0, m.st, m.stall, m.dp, m.sp, m.vel, m.valid, m.x};
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input int mg, input int gm,
                                      input logic t, input logic s, input logic h);
        mdl_t n;
        n      = m;
        n.sp   = 1'b0;
        n.dp   = 1'b0;
        n.lfsr = m.lfsr[0] ? ((m.lfsr >> 1) ^ 16'hB400) : (m.lfsr >> 1);
        if (s) begin
            n.st = 2'b01; n.valid = '0; n.x = '0; n.vel = 5'd6;
            n.gap = 7'(mg); n.ramp = '0; n.stall = 1'b0;
        end else if (m.st == 2'b01 && h) begin
            n.st = 2'b10;
        end else if (m.st == 2'b01 && t) begin
            for (int i = 0; i < 4; i++) begin
                if (m.valid[i]) begin
                    if (m.x[i] <= 10'd150) begin
                        n.valid[i] = 1'b0; n.x[i] = '0; n.dp = 1'b1;
                    end else begin
                        n.x[i] = m.x[i] - 10'(m.vel);
                    end
                end
            end
            if (m.gap != 0) begin
                n.gap = m.gap - 7'd1;
            end else if (m.valid == 4'hF) begin
                n.stall = 1'b1;
            end else begin
                int k;
                k = 0;
                while (m.valid[k]) k++;
                n.valid[k] = 1'b1;
                n.x[k]     = 10'd800;
                n.sp       = 1'b1;
                n.stall    = 1'b0;
                n.gap      = 7'(mg + (int'(m.lfsr) & gm));
            end
            if (m.ramp == 10'd599) begin
                n.ramp = '0;
                if (m.vel < 5'd15) n.vel = m.vel + 5'd1;
            end else begin
                n.ramp = m.ramp + 10'd1;
            end
        end
        return n;
    endfunction

    // One clock: drive at negedge, queue model outputs, compare after the edge
    task automatic cyc(input logic t, input logic s, input logic h);
        tick = t; start = s; halt = h;
        ma = mdl_step(ma, 30, 63, t, s, h);
        mb = mdl_step(mb, 2, 3, t, s, h);
        exp_a_q.push_back(pack_exp(ma));
        exp_b_q.push_back(pack_exp(mb));
        @(posedge clk);
        #1;
        chk("cyc_a", obs_a, exp_a_q.pop_front());
        chk("cyc_b", obs_b, exp_b_q.pop_front());
        @(negedge clk);
        tick = 1'b0; start = 1'b0; halt = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int k;
        logic [3:0][9:0] snap;
        logic [4:0] vsnap;

        rst = 1'b1; tick = 1'b0; start = 1'b0; halt = 1'b0;
        ma = mdl_reset(30);
        mb = mdl_reset(2);
        repeat (3) @(negedge clk);
        chk("rst_a", obs_a, pack_exp(ma));
        chk("rst_b", obs_b, pack_exp(mb));
        chk("rst_lfsr", dut_a.lfsr_q, 16'hACE1);
        rst = 1'b0;

        // IDLE ignores tick and halt
        repeat (3) cyc(1'b1, 1'b0, 1'b1);
        chk("idle_state", sched_state_a, 2'b00);
        chk("idle_valid", obs_valid_a, 4'b0000);

        // First spawn on the 31st tick after start
        cyc(1'b0, 1'b1, 1'b0);
        chk("start_state", sched_state_a, 2'b01);
        repeat (30) cyc(1'b1, 1'b0, 1'b0);
        chk("gap_no_spawn", obs_valid_a, 4'b0000);
        cyc(1'b1, 1'b0, 1'b0);
        chk("spawn_pulse", spawn_pulse_a, 1'b1);
        chk("spawn_valid", obs_valid_a, 4'b0001);
        chk("spawn_x", obs_x_a[9:0], 10'd800);
        cyc(1'b0, 1'b0, 1'b0);
        chk("notick_pulse", spawn_pulse_a, 1'b0);
        chk("notick_x", obs_x_a[9:0], 10'd800);
        cyc(1'b1, 1'b0, 1'b0);
        chk("scroll_x", obs_x_a[9:0], 10'd794);

        // Slot 0 reaches 152, scrolls to 146, then retires
        repeat (107) cyc(1'b1, 1'b0, 1'b0);
        chk("pre_despawn_x", obs_x_a[9:0], 10'd152);
        cyc(1'b1, 1'b0, 1'b0);
        chk("last_scroll_x", obs_x_a[9:0], 10'd146);
        chk("last_scroll_dp", despawn_pulse_a, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("despawn_valid0", obs_valid_a[0], 1'b0);
        chk("despawn_x0", obs_x_a[9:0], 10'd0);
        chk("despawn_pulse", despawn_pulse_a, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        chk("despawn_once", despawn_pulse_a, 1'b0);

        // Short-gap instance: lane full -> stall, then refill after a retire
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            if (spawn_stall_b) found = 1'b1;
        end
        chk("stall_seen", found, 1'b1);
        chk("stall_full", obs_valid_b, 4'hF);
        chk("stall_no_spawn", spawn_pulse_b, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            if (despawn_pulse_b) found = 1'b1;
        end
        chk("stall_despawn_seen", found, 1'b1);
        chk("stall_held", spawn_stall_b, 1'b1);
        chk("stall_despawn_nospawn", spawn_pulse_b, 1'b0);
        k = 0;
        while (k < 3 && mb.valid[k]) k++;
        cyc(1'b1, 1'b0, 1'b0);
        chk("refill_pulse", spawn_pulse_b, 1'b1);
        chk("refill_stall", spawn_stall_b, 1'b0);
        chk("refill_valid", obs_valid_b, 4'hF);
        chk("refill_x", obs_x_b[10*k +: 10], 10'd800);

        // halt with coincident tick freezes; FROZEN holds through ticks
        snap  = ma.x;
        vsnap = ma.vel;
        cyc(1'b1, 1'b0, 1'b1);
        chk("halt_state", sched_state_a, 2'b10);
        chk("halt_x", obs_x_a, snap);
        repeat (100) cyc(1'b1, 1'b0, 1'b1);
        chk("frozen_x", obs_x_a, snap);
        chk("frozen_vel", velocity_a, vsnap);
        chk("frozen_state", sched_state_a, 2'b10);
        cyc(1'b1, 1'b1, 1'b1);
        chk("restart_valid", obs_valid_a, 4'b0000);
        chk("restart_x", obs_x_a, 40'd0);
        chk("restart_vel", velocity_a, 5'd6);
        chk("restart_state", sched_state_a, 2'b01);

        // Velocity ramp and saturation
        repeat (599) cyc(1'b1, 1'b0, 1'b0);
        chk("ramp_599", velocity_a, 5'd6);
        cyc(1'b1, 1'b0, 1'b0);
        chk("ramp_600", velocity_a, 5'd7);
        repeat (4800) cyc(1'b1, 1'b0, 1'b0);
        chk("ramp_5400", velocity_a, 5'd15);
        repeat (600) cyc(1'b1, 1'b0, 1'b0);
        chk("ramp_sat", velocity_a, 5'd15);
        chk("ramp_sat_b", velocity_b, 5'd15);

        // Asynchronous reset between ticks
        cyc(1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        ma = mdl_reset(30);
        mb = mdl_reset(2);
        chk("async_rst_a", obs_a, pack_exp(ma));
        chk("async_rst_b", obs_b, pack_exp(mb));
        chk("async_rst_lfsr", dut_a.lfsr_q, 16'hACE1);
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b0, 1'b1, 1'b0);
        repeat (40) cyc(1'b1, 1'b0, 1'b0);
        chk("post_rst_spawned", obs_valid_a[0], 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
